fc_argmax_ctrl: RTL and testbench

FC_ARGMAX_CTRL -- requirements
Module: fc_argmax_ctrl

---
 rtl/cnn_pkg.sv | 15 +
 rtl/fc_max_step.sv | 24 ++
 rtl/fc_argmax_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fc_argmax_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FC/argmax sizes and controller state encoding
package cnn_pkg;

  localparam int ACC_W = 38;
  localparam int N_OUT = 10;
  localparam int IDX_W = $clog2(N_OUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SCAN   = 2'd2,
    ST_REPORT = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_max_step.sv
// rtl/fc_max_step.sv - combinational signed strict-greater compare/select step
module fc_max_step #(
  parameter int ACC_W = cnn_pkg::ACC_W,
  parameter int IDX_W = cnn_pkg::IDX_W
) (
  input  logic signed [ACC_W-1:0] cur_max,
  input  logic        [IDX_W-1:0] cur_idx,
  input  logic signed [ACC_W-1:0] cand,
  input  logic        [IDX_W-1:0] cand_idx,
  output logic signed [ACC_W-1:0] new_max,
  output logic        [IDX_W-1:0] new_idx
);

  // Candidate wins only when strictly greater, so equal scores keep the earlier index.
  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
    if (cand > cur_max) begin
      new_max = cand;
      new_idx = cand_idx;
    end
  end

endmodule

// File: rtl/fc_argmax_ctrl.sv
// rtl/fc_argmax_ctrl.sv - FC run control and argmax over neuron results (optional FC_TIMEOUT_EN done-wait timeout)
module fc_argmax_ctrl #(
  parameter int N_OUT       = cnn_pkg::N_OUT,
  parameter int ACC_W       = cnn_pkg::ACC_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       fc_enable,
  input  logic [N_OUT-1:0]           fc_done,
  input  logic [N_OUT*ACC_W-1:0]     fc_result,
  output logic                       busy,
  output logic                       class_valid,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic signed [ACC_W-1:0]    class_score,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  import cnn_pkg::*;

  fc_state_e               state_q, state_d;
  logic                    fc_enable_q, fc_enable_d;
  logic signed [ACC_W-1:0] cap_q [N_OUT];
  logic signed [ACC_W-1:0] cap_d [N_OUT];
  logic [IDX_W-1:0]        scan_cnt_q, scan_cnt_d;
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]        midx_q, midx_d;
  logic [IDX_W-1:0]        class_idx_q, class_idx_d;
  logic signed [ACC_W-1:0] class_score_q, class_score_d;

  logic signed [ACC_W-1:0] cand;
  logic signed [ACC_W-1:0] step_max;
  logic [IDX_W-1:0]        step_idx;
  logic signed [ACC_W-1:0] sel_max;
  logic [IDX_W-1:0]        sel_idx;
  logic                    all_done;
  logic                    start_accept;
  logic                    timeout_hit;

  assign all_done     = &fc_done;
  assign start_accept = (state_q == ST_IDLE) && start;
  assign cand         = cap_q[scan_cnt_q];

  fc_max_step #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_step (
    .cur_max  (max_q),
    .cur_idx  (midx_q),
    .cand     (cand),
    .cand_idx (scan_cnt_q),
    .new_max  (step_max),
    .new_idx  (step_idx)
  );

  // Index 0 seeds the running maximum; later indices go through the compare step.
  always_comb begin
    sel_max = step_max;
    sel_idx = step_idx;
    if (scan_cnt_q == '0) begin
      sel_max = cand;
      sel_idx = '0;
    end
  end

`ifdef FC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // RUN-cycle counter; restarts from zero every time RUN is entered.
  always_comb begin
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q;
    if (state_q == ST_RUN) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    if (start_accept) begin
      timeout_err_d = 1'b0;
    end else if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_RUN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and datapath control: run FC units, capture, scan, report.
  always_comb begin
    state_d       = state_q;
    fc_enable_d   = fc_enable_q;
    cap_d         = cap_q;
    scan_cnt_d    = scan_cnt_q;
    max_d         = max_q;
    midx_d        = midx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          fc_enable_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (all_done) begin
          for (int i = 0; i < N_OUT; i++) begin
            cap_d[i] = fc_result[i*ACC_W +: ACC_W];
          end
          fc_enable_d = 1'b0;
          scan_cnt_d  = '0;
          state_d     = ST_SCAN;
        end else if (timeout_hit) begin
          fc_enable_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_SCAN: begin
        max_d  = sel_max;
        midx_d = sel_idx;
        if (scan_cnt_q == LAST_IDX) begin
          class_idx_d   = sel_idx;
          class_score_d = sel_max;
          scan_cnt_d    = '0;
          state_d       = ST_REPORT;
        end else begin
          scan_cnt_d = scan_cnt_q + IDX_W'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        fc_enable_d = 1'b0;
      end
    endcase
  end

  // Controller state, captured results and published classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fc_enable_q   <= 1'b0;
      scan_cnt_q    <= '0;
      max_q         <= '0;
      midx_q        <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fc_enable_q   <= fc_enable_d;
      scan_cnt_q    <= scan_cnt_d;
      max_q         <= max_d;
      midx_q        <= midx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      for (int i = 0; i < N_OUT; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  assign fc_enable   = fc_enable_q;
  assign busy        = (state_q != ST_IDLE);
  assign class_valid = (state_q == ST_REPORT);
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// tb/tb_fc_argmax_ctrl.sv - directed self-checking bench for fc_argmax_ctrl
module tb_fc_argmax_ctrl;

  localparam int N  = 10;
  localparam int W  = 38;
  localparam int IW = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                fc_enable;
  logic [N-1:0]        fc_done;
  logic [N*W-1:0]      fc_result;
  logic                busy;
  logic                class_valid;
  logic [IW-1:0]       class_idx;
  logic signed [W-1:0] class_score;
  logic                timeout_err;

  logic signed [W-1:0] res [N];
  logic signed [W-1:0] min_v;

  int n_tests = 0;
  int n_fail  = 0;

  fc_argmax_ctrl #(
    .N_OUT       (N),
    .ACC_W       (W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .fc_enable   (fc_enable),
    .fc_done     (fc_done),
    .fc_result   (fc_result),
    .busy        (busy),
    .class_valid (class_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    fc_result = '0;
    for (int i = 0; i < N; i++) fc_result[i*W +: W] = res[i];
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input int c0, output int cyc);
    cyc = -1;
    for (int i = c0 + 1; i <= c0 + 40; i++) begin
      @(negedge clk);
      if (class_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; fc_done = '0;
    for (int i = 0; i < N; i++) res[i] = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL rst_fc_enable got=%b exp=0", fc_enable); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_tests++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL rst_class_valid got=%b exp=0", class_valid); end
    n_tests++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL rst_class_idx got=%0d exp=0", class_idx); end
    n_tests++; if (class_score !== '0) begin n_fail++; $display("FAIL rst_class_score got=%0d exp=0", class_score); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int c;
    res = '{38'sd5, -38'sd3, 38'sd100, 38'sd7, 38'sd0, 38'sd0, 38'sd0, 38'sd0, 38'sd0, -38'sd100};
    fc_done = '0;
    pulse_start();
    n_tests++; if (fc_enable !== 1'b1) begin n_fail++; $display("FAIL basic_enable got=%b exp=1", fc_enable); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
    repeat (2) @(negedge clk);
    fc_done = '1;
    @(negedge clk);
    n_tests++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL basic_enable_drop got=%b exp=0", fc_enable); end
    fc_done = '0;
    res[0] = 38'sd1000;
    res[2] = -38'sd1;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL basic_latency got=%0d exp=11", c); end
    n_tests++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL basic_idx got=%0d exp=2", class_idx); end
    n_tests++; if (class_score !== 38'sd100) begin n_fail++; $display("FAIL basic_score got=%0d exp=100", class_score); end
    @(negedge clk);
    n_tests++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", class_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=%b exp=0", busy); end
    n_tests++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL basic_hold_idx got=%0d exp=2", class_idx); end
  endtask

  task automatic test_tie();
    int c;
    for (int i = 0; i < N; i++) res[i] = -38'sd1;
    res[6] = 38'sd50;
    res[8] = 38'sd50;
    pulse_start();
    n_tests++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL tie_hold_prev got=%0d exp=2", class_idx); end
    @(negedge clk);
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL tie_latency got=%0d exp=11", c); end
    n_tests++; if (class_idx !== 4'd6) begin n_fail++; $display("FAIL tie_idx got=%0d exp=6", class_idx); end
    n_tests++; if (class_score !== 38'sd50) begin n_fail++; $display("FAIL tie_score got=%0d exp=50", class_score); end
  endtask

  task automatic test_signed();
    int c;
    min_v = {1'b1, {(W-1){1'b0}}};
    for (int i = 0; i < N; i++) res[i] = min_v;
    res[9] = min_v + 38'sd1;
    pulse_start();
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL signed_latency got=%0d exp=11", c); end
    n_tests++; if (class_idx !== 4'd9) begin n_fail++; $display("FAIL signed_idx got=%0d exp=9", class_idx); end
    n_tests++; if (class_score !== min_v + 38'sd1) begin n_fail++; $display("FAIL signed_score got=%0d exp=%0d", class_score, min_v + 38'sd1); end
  endtask

  task automatic test_staggered();
    int c;
    int extra;
    res = '{38'sd10, 38'sd20, 38'sd30, 38'sd40, 38'sd500, 38'sd60, 38'sd70, 38'sd80, 38'sd90, 38'sd95};
    fc_done = '0;
    pulse_start();
    for (int k = 0; k < N; k++) begin
      n_tests++; if (fc_enable !== 1'b1) begin n_fail++; $display("FAIL stagger_enable_k%0d got=%b exp=1", k, fc_enable); end
      start = (k == 4);
      fc_done[k] = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL stagger_enable_drop got=%b exp=0", fc_enable); end
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL stagger_latency got=%0d exp=11", c); end
    n_tests++; if (class_idx !== 4'd4) begin n_fail++; $display("FAIL stagger_idx got=%0d exp=4", class_idx); end
    n_tests++; if (class_score !== 38'sd500) begin n_fail++; $display("FAIL stagger_score got=%0d exp=500", class_score); end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (class_valid === 1'b1) extra++;
      if (fc_enable === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL stagger_extra_activity got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_scan();
    int c;
    int pulses;
    res = '{38'sd1, 38'sd2, 38'sd3, 38'sd4, 38'sd5, 38'sd6, 38'sd7, 38'sd8, 38'sd9, 38'sd10};
    pulse_start();
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midscan_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_busy got=%b exp=0", busy); end
    n_tests++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_enable got=%b exp=0", fc_enable); end
    n_tests++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_valid got=%b exp=0", class_valid); end
    n_tests++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL midscan_rst_idx got=%0d exp=0", class_idx); end
    n_tests++; if (class_score !== '0) begin n_fail++; $display("FAIL midscan_rst_score got=%0d exp=0", class_score); end
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (class_valid === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midscan_no_valid got=%0d exp=0", pulses); end
    res = '{38'sd5, -38'sd3, 38'sd100, 38'sd7, 38'sd0, 38'sd0, 38'sd0, 38'sd0, 38'sd0, -38'sd100};
    pulse_start();
    n_tests++; if (fc_enable !== 1'b1) begin n_fail++; $display("FAIL post_rst_enable got=%b exp=1", fc_enable); end
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=11", c); end
    n_tests++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL post_rst_idx got=%0d exp=2", class_idx); end
  endtask

`ifdef FC_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    int c;
    int pulses;
    fc_done = '0;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (fc_enable !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_tests++; if (cnt !== 16) begin n_fail++; $display("FAIL timeout_run_cycles got=%0d exp=16", cnt); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (class_valid === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL timeout_no_valid got=%0d exp=0", pulses); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    pulse_start();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL timeout_recover_latency got=%0d exp=11", c); end
  endtask
`else
  task automatic test_no_timeout();
    int c;
    fc_done = '0;
    pulse_start();
    repeat (40) @(negedge clk);
    n_tests++; if (fc_enable !== 1'b1) begin n_fail++; $display("FAIL wait_enable got=%b exp=1", fc_enable); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy got=%b exp=1", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wait_timeout_err got=%b exp=0", timeout_err); end
    fc_done = '1;
    @(negedge clk);
    fc_done = '0;
    wait_valid(1, c);
    n_tests++; if (c !== 11) begin n_fail++; $display("FAIL wait_latency got=%0d exp=11", c); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_staggered();
    test_reset_mid_scan();
`ifdef FC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
